regin_data_sel: RTL

REGIN_DATA_SEL -- requirements
Module: regin_data_sel

---
 rtl/regin_data_sel.sv | 120 ++++++++++++
 1 files changed

// File: rtl/regin_data_sel.sv
`default_nettype none
// ============================================================================
//  Module   : regin_data_sel
//  Purpose  : Registered source selector over data inputs, programmable
//             constants and pc, with a valid/ready output stage.
//  Revision : 1.0  initial release
// ============================================================================
module regin_data_sel #(
  parameter int WIDTH     = 16,
  parameter int NUM_IN    = 4,
  parameter int NUM_CONST = 3,
  localparam int SEL_W    = $clog2(NUM_IN + NUM_CONST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]        pc,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    const_we,
  input  logic [2:0]              const_addr,
  input  logic [WIDTH-1:0]        const_wdata,
  output logic                    sel_err,
  input  logic                    sel_err_clr
);

  localparam int c_PC_IDX = NUM_IN + NUM_CONST;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  const_q [NUM_CONST];

  logic              w_accept;
  logic              w_illegal;
  logic [WIDTH-1:0]  w_sel_val;

  // Constant bank: each register has its own reset value.
  for (genvar j = 0; j < NUM_CONST; j++) begin : g_const
    localparam logic [WIDTH-1:0] c_RST =
      (j == 0) ? WIDTH'(95)  :
      (j == 1) ? WIDTH'(200) :
      (j == 2) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        const_q[j] <= c_RST;
      end else if (const_we && (int'(const_addr) == j)) begin
        const_q[j] <= const_wdata;
      end
    end
  end

  always_comb begin
    w_sel_val = '0;
    w_illegal = (int'(sel) > c_PC_IDX);
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        w_sel_val = in_data[k*WIDTH +: WIDTH];
      end
    end
    for (int j = 0; j < NUM_CONST; j++) begin
      if (int'(sel) == NUM_IN + j) begin
        w_sel_val = const_q[j];
      end
    end
    if (int'(sel) == c_PC_IDX) begin
      w_sel_val = pc;
    end
  end

  assign in_ready = (state_q == EMPTY) || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    if (sel_err_clr) begin
      err_d = 1'b0;
    end
    // Set wins over a simultaneous clear.
    if (w_accept) begin
      state_d = FULL;
      data_d  = w_illegal ? '0 : w_sel_val;
      if (w_illegal) begin
        err_d = 1'b1;
      end
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel_err   = err_q;

endmodule
`default_nettype wire
